// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin stream mux: channel-index width and grant vector type.
package mux_pkg;

    localparam int unsigned GRANT_OH_MAX = 64;

    typedef logic [GRANT_OH_MAX-1:0] grant_oh_t;

    // A single-channel index still needs one bit so port widths stay legal.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr, wrapping N_CH-1 -> 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = sel_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             grant_vld
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest position back to the nearest so the closest request wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = SEL_W'((int'(ptr) + i) % N_CH);
            if (req[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_by_1_rr.sv
// N-channel registered stream mux with round-robin arbitration and one output stage.
// Optional macro MUX_N_BY_1_RR_FORCE_SEL_EN adds force_en/force_sel to pin the grant.
module mux_n_by_1_rr
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MUX_N_BY_1_RR_FORCE_SEL_EN
    input  logic                   force_en,
    input  logic [SEL_W-1:0]       force_sel,
`endif
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       out_sel
);

    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [SEL_W-1:0]  rr_grant;
    logic              rr_grant_vld;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              load_en;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_grant),
        .grant_vld (rr_grant_vld)
    );

`ifdef MUX_N_BY_1_RR_FORCE_SEL_EN
    // A forced index outside the channel range yields no grant at all.
    always_comb begin
        grant     = rr_grant;
        grant_vld = rr_grant_vld;
        if (force_en) begin
            grant     = force_sel;
            grant_vld = (int'(force_sel) < N_CH) && in_valid[force_sel];
        end
    end
`else
    always_comb begin
        grant     = rr_grant;
        grant_vld = rr_grant_vld;
    end
`endif

    assign load_en = !out_valid_q || out_ready;
    assign accept  = load_en && grant_vld;

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (grant == SEL_W'(c)) begin
                in_ready[c] = accept;
                sel_data    = in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_sel_d   = grant;
            rr_ptr_d    = grant;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Pointer resets to the last channel so the first search after reset starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;

endmodule
